// File: rtl/task_seq_arbiter_pkg.sv
// task_seq_arbiter_pkg: shared bus widths, sequencer state encoding and default timeout
package task_seq_arbiter_pkg;
    localparam int ADDR_W      = 11;
    localparam int WORD_W      = 16;
    localparam int DEF_TIMEOUT = 1023;
    typedef enum logic [2:0] {S_IDLE, S_ENABLE, S_START, S_WAIT, S_NEXT, S_FINISH} state_t;
endpackage

// File: rtl/task_seq_arbiter_if.sv
// task_seq_arbiter_if: task handshake and shared-memory bus between the sequencer and its task blocks
interface task_seq_arbiter_if #(parameter int NUM_TASKS = 4);
    import task_seq_arbiter_pkg::*;
    logic [NUM_TASKS-1:0]        task_en;
    logic [NUM_TASKS-1:0]        task_start;
    logic [NUM_TASKS-1:0]        task_done;
    logic [NUM_TASKS*ADDR_W-1:0] task_addr;
    logic [NUM_TASKS-1:0]        task_wr_en;
    logic [NUM_TASKS*WORD_W-1:0] task_wdata;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_wr_en;
    logic [WORD_W-1:0]           mem_wdata;
    modport master (
        output task_en, task_start, mem_addr, mem_wr_en, mem_wdata,
        input  task_done, task_addr, task_wr_en, task_wdata
    );
    modport slave (
        input  task_en, task_start, mem_addr, mem_wr_en, mem_wdata,
        output task_done, task_addr, task_wr_en, task_wdata
    );
endinterface

// File: rtl/task_next_sel.sv
// task_next_sel: finds the lowest set mask bit above cur, or the lowest overall when from_zero
module task_next_sel #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] cur,
    input  logic         from_zero,
    output logic [W-1:0] nxt,
    output logic         valid
);
    always_comb begin
        nxt   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (mask[i] && (from_zero || W'(i) > cur)) begin
                nxt   = W'(i);
                valid = 1'b1;
            end
    end
endmodule

// File: rtl/task_seq_arbiter.sv
// task_seq_arbiter: runs the masked task blocks one at a time in index order and
// grants the running task the single shared-memory port
module task_seq_arbiter
    import task_seq_arbiter_pkg::*;
#(
    parameter int NUM_TASKS = 4,
    parameter int IDX_W     = 2,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int TO_W      = 10
) (
    input  logic                 clock,
    input  logic                 nrst,
    input  logic                 go,
    input  logic [NUM_TASKS-1:0] task_mask,
    output logic                 busy,
    output logic                 seq_done,
    output logic                 timeout_err,
    output logic [IDX_W-1:0]     cur_task,
    task_seq_arbiter_if.master   bus
);
    state_t               state;
    logic [NUM_TASKS-1:0] mask_q;
    logic [TO_W-1:0]      cnt;
    logic [TO_W-1:0]      cnt_inc;
    logic [IDX_W-1:0]     nxt;
    logic                 nxt_vld;
    logic                 in_range;
    logic                 granted;
    logic                 cur_done;

    task_next_sel #(.N(NUM_TASKS), .W(IDX_W)) u_sel (
        .mask      (state == S_IDLE ? task_mask : mask_q),
        .cur       (cur_task),
        .from_zero (state == S_IDLE),
        .nxt       (nxt),
        .valid     (nxt_vld)
    );

    assign cnt_inc  = cnt + 1'b1;
    assign in_range = int'(cur_task) < NUM_TASKS;
    assign cur_done = in_range && bus.task_done[cur_task];
    assign granted  = in_range && (state == S_ENABLE || state == S_START || state == S_WAIT);
    assign bus.mem_addr  = granted ? bus.task_addr[cur_task*ADDR_W +: ADDR_W] : '0;
    assign bus.mem_wr_en = granted ? bus.task_wr_en[cur_task] : 1'b0;
    assign bus.mem_wdata = granted ? bus.task_wdata[cur_task*WORD_W +: WORD_W] : '0;

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state          <= S_IDLE;
            mask_q         <= '0;
            cnt            <= '0;
            cur_task       <= '0;
            busy           <= 1'b0;
            seq_done       <= 1'b0;
            timeout_err    <= 1'b0;
            bus.task_en    <= '0;
            bus.task_start <= '0;
        end else begin
            bus.task_en    <= '0;
            bus.task_start <= '0;
            seq_done       <= 1'b0;
            case (state)
                S_IDLE: if (go) begin
                    mask_q      <= task_mask;
                    timeout_err <= 1'b0;
                    busy        <= 1'b1;
                    if (nxt_vld) begin
                        cur_task    <= nxt;
                        bus.task_en <= NUM_TASKS'(1) << nxt;
                        state       <= S_ENABLE;
                    end else begin
                        seq_done <= 1'b1;
                        state    <= S_FINISH;
                    end
                end
                S_ENABLE: begin
                    bus.task_start <= NUM_TASKS'(1) << cur_task;
                    state          <= S_START;
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_inc;
                    if (cur_done)
                        state <= S_NEXT;
                    else if (cnt_inc == TO_W'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= S_NEXT;
                    end
                end
                S_NEXT: if (nxt_vld) begin
                    cur_task    <= nxt;
                    bus.task_en <= NUM_TASKS'(1) << nxt;
                    state       <= S_ENABLE;
                end else begin
                    seq_done <= 1'b1;
                    state    <= S_FINISH;
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_task_seq_arbiter.sv
// tb_task_seq_arbiter: randomized passes checked cycle by cycle against a schedule
// derived from the mask, per-task latencies and the timeout
module tb_task_seq_arbiter;
    localparam int NT    = 4;
    localparam int TO    = 15;
    localparam int NEVER = 1000;
    localparam int MAXN  = 256;

    logic          clock = 0;
    logic          nrst  = 1;
    logic          go    = 0;
    logic [NT-1:0] task_mask = '0;
    logic          busy, seq_done, timeout_err;
    logic [1:0]    cur_task;

    task_seq_arbiter_if #(.NUM_TASKS(NT)) bus();

    task_seq_arbiter #(.NUM_TASKS(NT), .IDX_W(2), .TIMEOUT(TO), .TO_W(10)) dut (
        .clock       (clock),
        .nrst        (nrst),
        .go          (go),
        .task_mask   (task_mask),
        .busy        (busy),
        .seq_done    (seq_done),
        .timeout_err (timeout_err),
        .cur_task    (cur_task),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    int          lat    [NT];
    bit          hold   [NT];
    bit          pend   [NT];
    int          rem    [NT];
    bit          done_m [NT];
    logic [10:0] wa     [NT];
    logic [15:0] wd     [NT];
    logic [10:0] da     [NT];
    logic        dw     [NT];
    logic [15:0] dd     [NT];
    bit          noise = 0;
    bit          stray = 0;
    int          last_cur = 0;
    bit          te_m = 0;

    int            n;
    int            e_grant [MAXN];
    logic [NT-1:0] e_en    [MAXN];
    logic [NT-1:0] e_st    [MAXN];
    bit            e_busy  [MAXN];
    bit            e_sd    [MAXN];
    bit            e_te    [MAXN];
    int            e_cur   [MAXN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add(input int g, input logic [NT-1:0] en, input logic [NT-1:0] st,
                       input bit b, input bit sd, input int cur);
        e_grant[n] = g;
        e_en[n]    = en;
        e_st[n]    = st;
        e_busy[n]  = b;
        e_sd[n]    = sd;
        e_te[n]    = te_m;
        e_cur[n]   = cur;
        n++;
    endtask

    // Expected per-cycle schedule, starting with the cycle after the edge that accepts go
    task automatic build(input logic [NT-1:0] m);
        n    = 0;
        te_m = 0;
        for (int i = 0; i < NT; i++)
            if (m[i]) begin
                add(i, NT'(1) << i, '0, 1, 0, i);
                add(i, '0, NT'(1) << i, 1, 0, i);
                for (int k = 0; k < (lat[i] > TO ? TO : lat[i]); k++)
                    add(i, '0, '0, 1, 0, i);
                if (lat[i] > TO) te_m = 1;
                add(-1, '0, '0, 1, 0, i);
                last_cur = i;
            end
        add(-1, '0, '0, 1, 1, last_cur);
        add(-1, '0, '0, 0, 0, last_cur);
    endtask

    task automatic models();
        logic [NT*11-1:0] a;
        logic [NT*16-1:0] d;
        logic [NT-1:0]    w;
        logic [NT-1:0]    dn;
        bit               rise;
        for (int i = 0; i < NT; i++) begin
            rise = 0;
            if (pend[i]) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    done_m[i] = 1;
                    pend[i]   = 0;
                    rise      = 1;
                end
            end
            if (bus.task_start[i] === 1'b1) begin
                pend[i] = 1;
                rem[i]  = lat[i];
            end
            if (bus.task_en[i] === 1'b1) begin
                done_m[i] = 0;
                pend[i]   = 0;
            end
            if (hold[i]) begin
                dw[i] = 1;
                da[i] = 11'h7FF;
                dd[i] = 16'hFFFF;
            end else if (noise) begin
                dw[i] = 1'($urandom);
                da[i] = 11'($urandom);
                dd[i] = 16'($urandom);
            end else begin
                dw[i] = rise;
                da[i] = wa[i];
                dd[i] = wd[i];
            end
            a[i*11 +: 11] = da[i];
            d[i*16 +: 16] = dd[i];
            w[i]          = dw[i];
            dn[i]         = done_m[i];
        end
        bus.task_addr  = a;
        bus.task_wdata = d;
        bus.task_wr_en = w;
        bus.task_done  = dn;
    endtask

    task automatic chk_cycle(input int t);
        int          g;
        logic [10:0] ea;
        logic        ew;
        logic [15:0] ed;
        g  = e_grant[t];
        ea = '0;
        ew = 1'b0;
        ed = '0;
        if (g >= 0) begin
            ea = da[g];
            ew = dw[g];
            ed = dd[g];
        end
        check("busy", busy, e_busy[t]);
        check("seq_done", seq_done, e_sd[t]);
        check("timeout_err", timeout_err, e_te[t]);
        check("task_en", bus.task_en, e_en[t]);
        check("task_start", bus.task_start, e_st[t]);
        check("cur_task", cur_task, e_cur[t]);
        check("mem_addr", bus.mem_addr, ea);
        check("mem_wr_en", bus.mem_wr_en, ew);
        check("mem_wdata", bus.mem_wdata, ed);
    endtask

    task automatic run_pass(input logic [NT-1:0] m);
        build(m);
        go        = 1;
        task_mask = m;
        for (int t = 0; t < n; t++) begin
            @(posedge clock);
            #1;
            go        = stray && (t < n - 1) && ($urandom_range(3) == 0);
            task_mask = NT'($urandom);
            models();
            #1 chk_cycle(t);
        end
        go = 0;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_seq_done"}, seq_done, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_cur_task"}, cur_task, 0);
        check({tag, "_task_en"}, bus.task_en, 0);
        check({tag, "_task_start"}, bus.task_start, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wr_en"}, bus.mem_wr_en, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    endtask

    task automatic clear_models();
        for (int i = 0; i < NT; i++) begin
            pend[i]   = 0;
            done_m[i] = 0;
            rem[i]    = 0;
        end
        last_cur = 0;
    endtask

    initial begin
        for (int i = 0; i < NT; i++) begin
            lat[i]  = 3;
            hold[i] = 0;
            wa[i]   = 11'(i + 8);
            wd[i]   = 16'(16'hA0 + i);
        end
        clear_models();
        #1 nrst = 0;
        #1 chk_zero("reset");
        models();
        repeat (2) @(posedge clock);
        #2 nrst = 1;
        @(posedge clock);
        #2;

        wa[0] = 11'h2;
        wd[0] = 16'h1;
        run_pass(4'b0001);

        noise = 1;
        lat[1] = 4;
        lat[3] = 2;
        run_pass(4'b1010);

        hold[2] = 1;
        run_pass(4'b0001);
        hold[2] = 0;

        lat[0] = 2;
        lat[1] = NEVER;
        run_pass(4'b0011);
        lat[1] = 3;
        run_pass(4'b0001);

        stray = 1;
        run_pass(4'b0000);
        run_pass(4'b0000);

        lat[2] = TO;
        lat[3] = TO + 1;
        run_pass(4'b1100);

        for (int p = 0; p < 30; p++) begin
            for (int i = 0; i < NT; i++) begin
                case ($urandom_range(9))
                    0:       lat[i] = NEVER;
                    1:       lat[i] = TO;
                    default: lat[i] = $urandom_range(1, 6);
                endcase
                hold[i] = ($urandom_range(7) == 0);
            end
            noise = 1'($urandom);
            run_pass(NT'($urandom));
        end

        for (int i = 0; i < NT; i++) hold[i] = 0;
        hold[0] = 1;
        lat[0]  = NEVER;
        stray   = 0;
        go      = 1;
        task_mask = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1 go = 0;
            models();
        end
        #1;
        check("wait_busy", busy, 1);
        check("wait_mem_wr_en", bus.mem_wr_en, 1);
        check("wait_mem_addr", bus.mem_addr, 11'h7FF);
        nrst = 0;
        #1 chk_zero("async");
        @(negedge clock);
        nrst = 1;
        clear_models();
        hold[0] = 0;
        @(posedge clock);
        #1 models();
        #1 chk_zero("post_rst");
        lat[0] = 3;
        lat[2] = 4;
        run_pass(4'b0101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
